// File: rtl/ds192_sel_rgb565_if.sv
// Pixel stream bundle for the 256x256 -> 192x192 selection downscaler.
// The source drives din every clock; the sink takes dout on each write_en pulse.
interface ds192_sel_rgb565_if;
  logic [15:0] din;
  logic [15:0] dout;
  logic        write_en;

  modport master (output din, input dout, input write_en);
  modport slave  (input din, output dout, output write_en);
endinterface

// File: rtl/ds192_sel_rgb565.sv
// Streaming RGB565 downscaler that drops every DEC_N-th column and row.
// Each channel is widened to 8 bits, selected, then packed back to RGB565.
module ds192_chan_sel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       keep_i,
  input  logic [7:0] chan_i,
  output logic [7:0] chan_o
);
  logic [7:0] chan_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      chan_q <= 8'h00;
    else if (keep_i) chan_q <= chan_i;
  end

  assign chan_o = chan_q;
endmodule

module ds192_sel_rgb565 #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int DEC_N   = 4,
  parameter int DROP_PH = 3
) (
  input logic               clk,
  input logic               rst_n,
  ds192_sel_rgb565_if.slave px
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          we_q;
  logic          keep;
  logic [7:0]    r8, g8, b8;
  logic [7:0]    r_q, g_q, b_q;
  logic          unused_lsb;

  // Power-of-two frame dimensions let both counters wrap without an explicit compare.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == CW'(IMG_W - 1)) row_d = row_q + 1'b1;
  end

  assign keep = ((int'(col_q) % DEC_N) != DROP_PH) &&
                ((int'(row_q) % DEC_N) != DROP_PH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      we_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      we_q  <= keep;
    end
  end

  assign r8 = {px.din[15:11], px.din[15:13]};
  assign g8 = {px.din[10:5],  px.din[10:9]};
  assign b8 = {px.din[4:0],   px.din[4:2]};

  ds192_chan_sel u_sel_r (.clk(clk), .rst_n(rst_n), .keep_i(keep), .chan_i(r8), .chan_o(r_q));
  ds192_chan_sel u_sel_g (.clk(clk), .rst_n(rst_n), .keep_i(keep), .chan_i(g8), .chan_o(g_q));
  ds192_chan_sel u_sel_b (.clk(clk), .rst_n(rst_n), .keep_i(keep), .chan_i(b8), .chan_o(b_q));

  // Replicated low bits are discarded on repack, which makes the round trip exact.
  assign px.dout     = {r_q[7:3], g_q[7:2], b_q[7:3]};
  assign px.write_en = we_q;
  assign unused_lsb  = ^{r_q[2:0], g_q[1:0], b_q[2:0]};
endmodule

// File: tb/tb_ds192_sel_rgb565.sv
// Scoreboard bench for ds192_sel_rgb565: a pixel-position model predicts which
// pixels are kept, queues them, and matches them against write_en/dout.
module tb_ds192_sel_rgb565;
  logic clk = 1'b0;
  logic rst_n;

  ds192_sel_rgb565_if px();

  ds192_sel_rgb565 dut (.clk(clk), .rst_n(rst_n), .px(px));

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mcol    = 0;
  int          mrow    = 0;
  int          pulses  = 0;
  int          cap     = 0;
  int          k2      = 0;
  logic [15:0] sb[$];
  logic [15:0] out1[$];
  logic [15:0] exp_last = 16'h0000;
  logic        exp_we   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one pixel (or a reset cycle), advance the model, then check after the edge.
  task automatic drive(input logic [15:0] d, input logic rstn);
    logic [15:0] got;
    bit          keep;
    px.din = d;
    rst_n  = rstn;
    if (!rstn) begin
      mcol = 0; mrow = 0;
      exp_we = 1'b0; exp_last = 16'h0000;
      sb.delete();
    end else begin
      keep = ((mcol % 4) != 3) && ((mrow % 4) != 3);
      exp_we = keep;
      if (keep) begin
        sb.push_back(d);
        exp_last = d;
      end
      mcol++;
      if (mcol == 256) begin
        mcol = 0;
        mrow = (mrow + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
    check_eq("write_en", 32'(px.write_en), 32'(exp_we));
    if (px.write_en) begin
      pulses++;
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check_eq("dout_kept", 32'(px.dout), 32'(got));
        if (cap == 1) out1.push_back(px.dout);
        else if (cap == 2 && k2 < out1.size()) begin
          check_eq("frame2_vs_frame1", 32'(px.dout), 32'(out1[k2]));
          k2++;
        end
      end
    end else begin
      check_eq("dout_hold", 32'(px.dout), 32'(exp_last));
    end
  endtask

  initial begin
    int p_start;
    int p_row3;
    logic [15:0] pat[5];
    pat = '{16'h0000, 16'hFFFF, 16'h8410, 16'h07E0, 16'h001F};
    px.din = 16'h0000;
    rst_n  = 1'b0;

    // Reset held two clocks, then first pixel appears one edge later.
    drive(16'h1234, 1'b0);
    drive(16'h5678, 1'b0);
    check_eq("reset_dout", 32'(px.dout), 32'h0);
    check_eq("reset_we", 32'(px.write_en), 32'h0);
    drive(16'hF81F, 1'b1);
    check_eq("first_dout", 32'(px.dout), 32'hF81F);
    check_eq("first_we", 32'(px.write_en), 32'h1);

    // Round trip of extreme colours on kept columns 0,1,2,4,5 of row 0.
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) drive(16'hAAAA, 1'b1);
      else        drive(pat[(i < 3) ? i : i - 1], 1'b1);
      if (i != 3) check_eq("round_trip", 32'(px.dout), 32'(pat[(i < 3) ? i : i - 1]));
    end

    // Mid-frame reset at pixel 1000; next pixel restarts at (0,0).
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 1000; i++) drive(16'(i), 1'b1);
    drive(16'h03E8, 1'b0);
    check_eq("midrst_dout", 32'(px.dout), 32'h0);
    check_eq("midrst_we", 32'(px.write_en), 32'h0);
    drive(16'hABCD, 1'b1);
    check_eq("after_rst_we", 32'(px.write_en), 32'h1);
    check_eq("after_rst_dout", 32'(px.dout), 32'hABCD);

    // Full frame of index pixels, then the start of the next frame back-to-back.
    drive(16'h0000, 1'b0);
    p_start = pulses;
    p_row3  = 0;
    cap     = 1;
    for (int i = 0; i < 65536; i++) begin
      drive(16'(i), 1'b1);
      if (i == 255) check_eq("row0_col255_hold", 32'(px.dout), 32'd254);
      if (i == 767) p_row3 = pulses;
      if (i == 1023) check_eq("row3_pulses", 32'(pulses - p_row3), 32'd0);
      if (i == 1024) check_eq("row4_first", 32'(px.dout), 32'd1024);
    end
    check_eq("frame1_pulses", 32'(pulses - p_start), 32'd36864);
    check_eq("frame1_captured", 32'(out1.size()), 32'd36864);

    cap = 2;
    k2  = 0;
    p_start = pulses;
    for (int i = 0; i < 4096; i++) drive(16'(i), 1'b1);
    check_eq("frame2_pulses_16rows", 32'(pulses - p_start), 32'd2304);
    check_eq("frame2_compared", 32'(k2), 32'd2304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
